decode_cycle: RTL

Second pipeline stage of the 5-stage RV32I core, directly downstream of the fetch stage. Consumes `InstrD`, `PCD` and `PCPlus4D`. Decodes control, reads the 32×32 register file, and sign-extends the immediate. Registers everything into the ID/EX pipeline register for the execute stage, and owns the architectural register file, which is written by the writeback stage.

---
 rtl/decode_cycle.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, 32x32 register file, immediate extension and ID/EX register.
// Optional DECODE_BYPASS_EN: same-cycle writeback data is forwarded onto rs1/rs2 reads.
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } idex_t;

  idex_t       idex_d, idex_q;
  logic [31:0] rf_q [32];

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        funct7b5;
  logic [1:0]  imm_src, alu_op;
  logic [31:0] rd1, rd2;

  assign op       = InstrD[6:0];
  assign rd       = InstrD[11:7];
  assign funct3   = InstrD[14:12];
  assign rs1      = InstrD[19:15];
  assign rs2      = InstrD[24:20];
  assign funct7b5 = InstrD[30];

  // Register file: reset clears every entry and wins over a concurrent writeback.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (RegWriteW && (RdW != 5'd0)) begin
      rf_q[RdW] <= ResultW;
    end
  end

  always_comb begin
    rd1 = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    rd2 = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
`ifdef DECODE_BYPASS_EN
    if (RegWriteW && (RdW != 5'd0) && (RdW == rs1)) rd1 = ResultW;
    if (RegWriteW && (RdW != 5'd0) && (RdW == rs2)) rd2 = ResultW;
`endif
  end

  // Don't-care decoder fields (R-type ImmSrc, jal ALUSrc/ALUOp) resolve to 0.
  always_comb begin
    idex_d          = '0;
    imm_src         = 2'b00;
    alu_op          = 2'b00;
    case (op)
      7'b0000011: begin idex_d.reg_write = 1'b1; idex_d.alu_src = 1'b1; idex_d.result_src = 2'b01; end
      7'b0100011: begin imm_src = 2'b01; idex_d.alu_src = 1'b1; idex_d.mem_write = 1'b1; end
      7'b0110011: begin idex_d.reg_write = 1'b1; alu_op = 2'b10; end
      7'b1100011: begin imm_src = 2'b10; idex_d.branch = 1'b1; alu_op = 2'b01; end
      7'b0010011: begin idex_d.reg_write = 1'b1; idex_d.alu_src = 1'b1; alu_op = 2'b10; end
      7'b1101111: begin
        idex_d.reg_write  = 1'b1;
        imm_src           = 2'b11;
        idex_d.result_src = 2'b10;
        idex_d.jump       = 1'b1;
      end
      default: ;
    endcase

    case (alu_op)
      2'b01:   idex_d.alu_ctrl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  idex_d.alu_ctrl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  idex_d.alu_ctrl = 3'b101;
          3'b110:  idex_d.alu_ctrl = 3'b011;
          3'b111:  idex_d.alu_ctrl = 3'b010;
          default: idex_d.alu_ctrl = 3'b000;
        endcase
      end
      default: idex_d.alu_ctrl = 3'b000;
    endcase

    case (imm_src)
      2'b00: idex_d.imm = {{20{InstrD[31]}}, InstrD[31:20]};
      2'b01: idex_d.imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10: idex_d.imm = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: idex_d.imm = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
    endcase

    idex_d.rd1      = rd1;
    idex_d.rd2      = rd2;
    idex_d.rs1      = rs1;
    idex_d.rs2      = rs2;
    idex_d.rd       = rd;
    idex_d.pc       = PCD;
    idex_d.pc_plus4 = PCPlus4D;
  end

  always_ff @(posedge clk) begin
    if (!rst || FlushE) idex_q <= '0;
    else                idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alu_src;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUControlE = idex_q.alu_ctrl;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;

endmodule
